// File: rtl/count_step_checker.sv
// Step monitor for a 3-bit up/down counter: checks each observed count against
// the step implied by the previous cycle's mode/enable and reports errors and wraps.
module count_step_checker #(
    parameter int unsigned SYNC_CYCLES = 1,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 m,
    input  logic                 ta,
    input  logic                 qa,
    input  logic                 qb,
    input  logic                 qc,
    output logic                 tracking,
    output logic [2:0]           exp_count,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 wrap_up,
    output logic                 wrap_down
);

    localparam int unsigned SYNC_W = 4;

    typedef enum logic [0:0] {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_prev;
    logic              r_prev_m;
    logic              r_prev_ta;
    logic [SYNC_W-1:0] r_sync_cnt;
    logic [2:0]        w_cur;
    logic [2:0]        w_exp;
    logic              w_err;
    logic              w_wrap_up;
    logic              w_wrap_down;

    assign w_cur     = {qa, qb, qc};
    assign tracking  = (r_state == ST_TRACK);
    assign exp_count = (r_state == ST_TRACK) ? w_exp : 3'd0;

    // Counter responds one cycle late, so the step is predicted from last cycle's m/ta.
    always_comb begin
        w_exp = r_prev;
        if (r_prev_ta) begin
            w_exp = r_prev_m ? (r_prev + 3'd1) : (r_prev - 3'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An unknown sample fails the equality test and lands in the error branch.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_wrap_up   = 1'b0;
        w_wrap_down = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (r_sync_cnt == SYNC_W'(SYNC_CYCLES - 1)) begin
                    w_state_nxt = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (w_cur == w_exp) begin
                    w_wrap_up   = r_prev_ta & r_prev_m & (r_prev == 3'd7);
                    w_wrap_down = r_prev_ta & ~r_prev_m & (r_prev == 3'd0);
                end else begin
                    w_err = 1'b1;
                end
            end
        endcase
        if (clr) begin
            w_state_nxt = ST_SYNC;
            w_err       = 1'b0;
            w_wrap_up   = 1'b0;
            w_wrap_down = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev     <= 3'd0;
            r_prev_m   <= 1'b0;
            r_prev_ta  <= 1'b0;
            r_sync_cnt <= '0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            wrap_up    <= 1'b0;
            wrap_down  <= 1'b0;
        end else begin
            r_prev    <= w_cur;
            r_prev_m  <= m;
            r_prev_ta <= ta;
            err_pulse <= w_err;
            wrap_up   <= w_wrap_up;
            wrap_down <= w_wrap_down;
            if (clr) begin
                r_sync_cnt <= '0;
                err_sticky <= 1'b0;
                err_count  <= '0;
            end else begin
                if (w_err) begin
                    err_sticky <= 1'b1;
                    if (err_count != '1) begin
                        err_count <= err_count + ERR_CNT_W'(1);
                    end
                end
                if (r_state == ST_SYNC) begin
                    r_sync_cnt <= r_sync_cnt + SYNC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_count_step_checker.sv
// Directed bench for count_step_checker; a second instance with a 2-bit error counter covers saturation.
module tb_count_step_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       m;
    logic       ta;
    logic       qa;
    logic       qb;
    logic       qc;

    logic       trk_a, ep_a, es_a, wu_a, wd_a;
    logic [2:0] ex_a;
    logic [7:0] ec_a;
    logic       trk_b, ep_b, es_b, wu_b, wd_b;
    logic [2:0] ex_b;
    logic [1:0] ec_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_step_checker #(.SYNC_CYCLES(1), .ERR_CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .clr(clr), .m(m), .ta(ta),
        .qa(qa), .qb(qb), .qc(qc),
        .tracking(trk_a), .exp_count(ex_a), .err_pulse(ep_a), .err_sticky(es_a),
        .err_count(ec_a), .wrap_up(wu_a), .wrap_down(wd_a)
    );

    count_step_checker #(.SYNC_CYCLES(1), .ERR_CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .clr(clr), .m(m), .ta(ta),
        .qa(qa), .qb(qb), .qc(qc),
        .tracking(trk_b), .exp_count(ex_b), .err_pulse(ep_b), .err_sticky(es_b),
        .err_count(ec_b), .wrap_up(wu_b), .wrap_down(wd_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/trk"}, 16'(trk_a), 16'h0);
        check({tag, "/exp"}, 16'(ex_a),  16'h0);
        check({tag, "/ep"},  16'(ep_a),  16'h0);
        check({tag, "/es"},  16'(es_a),  16'h0);
        check({tag, "/ec"},  16'(ec_a),  16'h0);
        check({tag, "/wu"},  16'(wu_a),  16'h0);
        check({tag, "/wd"},  16'(wd_a),  16'h0);
        check({tag, "/sat_all"}, 16'({trk_b, ex_b, ep_b, es_b, ec_b, wu_b, wd_b}), 16'h0);
    endtask

    // Present one counter sample plus m/ta, clock it, then check the registered status.
    task automatic step(input string tag, input logic [2:0] v, input logic mm, input logic tt,
                        input logic trk, input logic [2:0] ex, input logic ep, input logic es,
                        input logic [7:0] ec, input logic wu, input logic wd);
        {qa, qb, qc} = v;
        m  = mm;
        ta = tt;
        @(posedge clk);
        #1;
        check({tag, "/trk"}, 16'(trk_a), 16'(trk));
        check({tag, "/exp"}, 16'(ex_a),  16'(ex));
        check({tag, "/ep"},  16'(ep_a),  16'(ep));
        check({tag, "/es"},  16'(es_a),  16'(es));
        check({tag, "/ec"},  16'(ec_a),  16'(ec));
        check({tag, "/wu"},  16'(wu_a),  16'(wu));
        check({tag, "/wd"},  16'(wd_a),  16'(wd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clr   = 1'b0;
        m     = 1'b1;
        ta    = 1'b1;
        {qa, qb, qc} = 3'd0;
        #12;
        check_all_zero("reset0");
        #8;
        reset = 1'b0;

        // Count up from 0 for 20 cycles; wrap after each 7->0.
        for (int i = 0; i < 20; i++) begin
            step($sformatf("up%0d", i), 3'(i % 8), 1'b1, 1'b1, 1'b1, 3'((i + 1) % 8),
                 1'b0, 1'b0, 8'd0, (i == 8) || (i == 16), 1'b0);
        end

        // Direction change through 0 -> 7 and back up.
        step("dir4", 3'd4, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step("dir5", 3'd5, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step("dir6", 3'd6, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step("dir7", 3'd7, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step("dn0",  3'd0, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        step("dn7",  3'd7, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        step("dn6",  3'd6, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step("dn5",  3'd5, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step("dn4",  3'd4, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step("rev3", 3'd3, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

        // Hold at 4, then an illegal move to 5 while held.
        step("hold_in", 3'd4, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("hold%0d", i), 3'd4, 1'b1, 1'b0, 1'b1, 3'd4,
                 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        end
        step("hold_bad", 3'd5, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
        step("hold_rs",  3'd4, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);

        // Glitch: 3 where 5 is expected, then resync on 4,5,6.
        step("glitch", 3'd3, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
        step("rs4",    3'd4, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
        step("rs5",    3'd5, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
        step("rs6",    3'd6, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
        check("sat_pre", 16'(ec_b), 16'd2);

        // Clear, sync, then five illegal steps; the 2-bit counter stops at 3.
        clr = 1'b1;
        step("clr1", 3'd7, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        clr = 1'b0;
        check("sat_clr", 16'(ec_b), 16'd0);
        step("sync1", 3'd7, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("bad%0d", i), 3'(i), 1'b1, 1'b0, 1'b1, 3'(i),
                 1'b1, 1'b1, 8'(i + 1), 1'b0, 1'b0);
            check($sformatf("sat_ep%0d", i), 16'(ep_b), 16'd1);
            check($sformatf("sat_ec%0d", i), 16'(ec_b), (i < 2) ? 16'(i + 1) : 16'd3);
        end
        step("sat_ok", 3'd4, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
        check("sat_hold", 16'(ec_b), 16'd3);

        // clr together with a mismatch: nothing counted, one sync cycle ignored.
        clr = 1'b1;
        step("clr_mm", 3'd6, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        clr = 1'b0;
        step("sync2",  3'd2, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step("trk2",   3'd2, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step("pre_rst", 3'd5, 1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);

        // Asynchronous reset between edges clears everything at once.
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        #3;
        reset = 1'b0;
        step("post0", 3'd0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step("post1", 3'd1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_step_checker.md
Name: count_step_checker

Overview:
- Downstream monitor for the 3-bit synchronous up/down counter. It observes the counter's outputs qa/qb/qc and the counter's own mode (m) and enable (ta) inputs.
- Every clock it checks that the count advanced legally (up, down or hold) relative to the previous cycle, and reports wrap events.
- It flags, counts and latches illegal steps, so both the self-checking bench and on-chip debug logic can consume its results.

Parameters:
- SYNC_CYCLES, 1: clock cycles ignored after reset or clr before checking starts (1 to 15).
- ERR_CNT_W, 8: width of the saturating error counter (2 to 16).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of error status; restarts the sync phase.
- m  in  1  counter mode, same net as the counter's m; 1 = up, 0 = down.
- ta  in  1  counter enable, same net as the counter's ta; 1 = count, 0 = hold.
- qa  in  1  counter output bit 2 (MSB).
- qb  in  1  counter output bit 1.
- qc  in  1  counter output bit 0 (LSB).
- tracking  out  1  high while the checker is in the TRACK state.
- exp_count  out  3  expected count for the current cycle; valid while tracking.
- err_pulse  out  1  one-cycle flag for an illegal step.
- err_sticky  out  1  latched error flag; cleared only by reset or clr.
- err_count  out  ERR_CNT_W  saturating count of illegal steps.
- wrap_up  out  1  one-cycle pulse for a legal 7->0 step in up mode.
- wrap_down  out  1  one-cycle pulse for a legal 0->7 step in down mode.

Behaviour:
- Definitions:
  - cur = {qa,qb,qc}, sampled on every rising clk.
  - Internal registers: prev (3b), prev_m, prev_ta, sync_cnt, state.
  - Registers are updated every cycle: prev<=cur, prev_m<=m, prev_ta<=ta.
- Reset (async, any time, including mid-operation):
  - state=SYNC, sync_cnt=0, prev=0, prev_m=0, prev_ta=0.
  - All outputs 0: tracking=0, exp_count=0, err_pulse=0, err_sticky=0, err_count=0, wrap_up=0, wrap_down=0.
- Expected-value rule (mod-8 arithmetic):
  - exp = prev_ta ? (prev_m ? prev+1 : prev-1) : prev.
  - 7+1 wraps to 0; 0-1 wraps to 7.
  - The counter's one-cycle latency is accounted for by using m/ta from the previous cycle.
  - exp_count is driven combinationally from the registers and reads 0 outside TRACK.
- State machine:
  - SYNC: no checking. sync_cnt increments each cycle; when sync_cnt reaches SYNC_CYCLES-1, go to TRACK on the next edge.
  - TRACK: at each edge compare cur vs exp.
    - Mismatch: err_pulse<=1 for exactly one cycle; err_sticky<=1; err_count increments, saturating at all-ones.
    - Match: err_pulse<=0.
  - FSM is SYNC->TRACK only. An error does not leave TRACK; the checker resynchronises by taking prev from the actual sampled value.
- Output latency: all status outputs are registered. A flag is visible in the cycle after the edge at which the offending count was sampled.
- Wrap pulses (registered, one cycle; asserted only in TRACK on a matching step):
  - wrap_up: prev=7, cur=0, prev_ta=1, prev_m=1.
  - wrap_down: prev=0, cur=7, prev_ta=1, prev_m=0.
  - An illegal step never produces a wrap pulse.
- Mode change mid-run: m toggling is legal at any cycle. The step after the toggle uses the new direction (rule above), and the count reverses with no error.
- Hold: with ta=0, cur must equal prev. Any change is an error.
- clr (synchronous):
  - Clears err_sticky, err_count, err_pulse, wrap_up, wrap_down and sync_cnt; forces state=SYNC.
  - clr has priority over a simultaneous mismatch: that mismatch is not counted.
  - prev/prev_m/prev_ta still update during clr.
- Saturation: err_count never wraps. At all-ones, further errors keep err_pulse and err_sticky behaviour but leave the count unchanged.
- X on qa/qb/qc in TRACK is treated as a mismatch (bench must drive known values).

Test Plan:
1. Counting up: reset high 20 ns, then m=1, ta=1, counter running from 0, 20 cycles -> err_count=0; wrap_up pulses exactly once per 8 cycles (after the 7->0 step); tracking=1 from cycle SYNC_CYCLES onward.
2. Direction change: m=0 for 6 cycles (0,7,6,5,4,3), then m=1 -> wrap_down pulses once after 0->7; count reverses at the toggle with no error; err_sticky=0.
3. Hold and illegal move: ta=0 with count held at 4 for 5 cycles -> no error. Force count to 5 while ta=0 -> err_pulse high one cycle, err_sticky=1, err_count=1.
4. Glitch and resync: up mode, force 3 where 5 is expected, then 4,5,6 -> exactly one error (err_count=1); no further errors; no wrap pulse on the bad step.
5. Saturation: ERR_CNT_W=2, inject 5 illegal steps -> err_count=3; err_pulse is asserted on each illegal step.
6. clr and reset:
   - Assert clr in the same cycle as a mismatch -> err_count stays 0, err_sticky=0, tracking=0 for SYNC_CYCLES cycles.
   - Assert reset asynchronously mid-cycle -> all outputs 0 immediately, without waiting for a clk edge.
